fp_add_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision adder controller.
- Sequences the existing signed-magnitude fraction ALU: bigalu, instantiated with N=24.
- Handles unpack, exponent alignment, add, normalization and pack; one operation in flight at a time.
- Sits between the operand-issue logic and the result bus, with a Start/Ready/Done handshake.

---
 rtl/fp_add_seq.sv | 190 +++++++++++++++++++
 tb/tb_fp_add_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq.sv
// Multi-cycle FP32 adder: unpack, align, add via bigalu, normalize, pack.
// One operation in flight; Start/Ready/Done handshake; truncating, no rounding.

module bigalu #(
    parameter int N = 24
) (
    input  logic [N-1:0] fracA,
    input  logic [N-1:0] fracB,
    input  logic         signA,
    input  logic         signB,
    output logic [N:0]   mag,
    output logic         sign,
    output logic         zero
);
    always_comb begin
        mag  = '0;
        sign = signA;
        if (signA == signB) begin
            mag = {1'b0, fracA} + {1'b0, fracB};
        end else if (fracA >= fracB) begin
            mag = {1'b0, fracA} - {1'b0, fracB};
        end else begin
            mag  = {1'b0, fracB} - {1'b0, fracA};
            sign = signB;
        end
        zero = (mag == '0);
    end
endmodule

module fp_add_seq #(
    parameter int MAXSHIFT = 25
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Ready,
    output logic        Done,
    output logic [31:0] Result,
    output logic        Overflow
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    localparam logic [7:0] MaxShift = 8'(MAXSHIFT);

    state_t      state, stateNext;
    logic        signA, signB, ccn;
    logic [23:0] fracA, fracB, frac;
    logic [7:0]  diff;
    logic [8:0]  expR;

    logic        loadRes, ovfNext;
    logic [31:0] resNext;

    logic [7:0]  expAIn, expBIn;
    logic [23:0] fracAIn, fracBIn;
    logic        nanIn, swapIn;

    logic [24:0] aluMag;
    logic        aluSign, aluZero;

    assign expAIn  = A[30:23];
    assign expBIn  = B[30:23];
    assign fracAIn = (expAIn == 8'd0) ? 24'd0 : {1'b1, A[22:0]};
    assign fracBIn = (expBIn == 8'd0) ? 24'd0 : {1'b1, B[22:0]};
    assign nanIn   = (expAIn == 8'hFF) || (expBIn == 8'hFF);
    assign swapIn  = expBIn > expAIn;

    bigalu #(.N(24)) uAlu (
        .fracA (fracA),
        .fracB (fracB),
        .signA (signA),
        .signB (signB),
        .mag   (aluMag),
        .sign  (aluSign),
        .zero  (aluZero)
    );

    assign Ready = (state == IDLE);
    assign Done  = (state == DONE);

    // Result/Overflow load on the edge entering DONE so they are valid while Done is high.
    always_comb begin
        stateNext = state;
        loadRes   = 1'b0;
        resNext   = 32'h0;
        ovfNext   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (nanIn) begin
                        stateNext = DONE;
                        loadRes   = 1'b1;
                        resNext   = 32'h7FC00000;
                    end else begin
                        stateNext = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (diff == 8'd0) stateNext = ADD;
            end
            ADD: begin
                if (aluZero) begin
                    stateNext = DONE;
                    loadRes   = 1'b1;
                end else begin
                    stateNext = NORM;
                end
            end
            NORM: begin
                if (expR == 9'd255) begin
                    stateNext = DONE;
                    loadRes   = 1'b1;
                    resNext   = {ccn, 8'hFF, 23'd0};
                    ovfNext   = 1'b1;
                end else if (frac[23]) begin
                    stateNext = DONE;
                    loadRes   = 1'b1;
                    resNext   = {ccn, expR[7:0], frac[22:0]};
                end else if (expR == 9'd1) begin
                    stateNext = DONE;
                    loadRes   = 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Result   <= 32'h0;
            Overflow <= 1'b0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            ccn      <= 1'b0;
            fracA    <= 24'd0;
            fracB    <= 24'd0;
            frac     <= 24'd0;
            diff     <= 8'd0;
            expR     <= 9'd0;
        end else begin
            state <= stateNext;
            if (loadRes) begin
                Result   <= resNext;
                Overflow <= ovfNext;
            end
            case (state)
                IDLE: begin
                    if (Start && !nanIn) begin
                        signA <= swapIn ? B[31]   : A[31];
                        signB <= swapIn ? A[31]   : B[31];
                        fracA <= swapIn ? fracBIn : fracAIn;
                        fracB <= swapIn ? fracAIn : fracBIn;
                        diff  <= swapIn ? (expBIn - expAIn) : (expAIn - expBIn);
                        expR  <= {1'b0, swapIn ? expBIn : expAIn};
                    end
                end
                ALIGN: begin
                    if (diff >= MaxShift) begin
                        fracB <= 24'd0;
                        diff  <= 8'd0;
                    end else if (diff != 8'd0) begin
                        fracB <= fracB >> 1;
                        diff  <= diff - 8'd1;
                    end
                end
                ADD: begin
                    ccn <= aluSign;
                    if (aluMag[24]) begin
                        frac <= aluMag[24:1];
                        expR <= expR + 9'd1;
                    end else begin
                        frac <= aluMag[23:0];
                    end
                end
                NORM: begin
                    if (stateNext == NORM) begin
                        frac <= frac << 1;
                        expR <= expR - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: arithmetic reference model, per-Done scoreboard, directed vectors.

module tb_fp_add_seq;
    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [31:0] A, B;
    logic        Ready, Done, Overflow;
    logic [31:0] Result;

    int checks   = 0;
    int failures = 0;

    fp_add_seq #(.MAXSHIFT(25)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .Ready    (Ready),
        .Done     (Done),
        .Result   (Result),
        .Overflow (Overflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] r;
        bit          ov;
        int          lat;
        time         t0;
    } exp_t;

    exp_t expQ[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: real-valued alignment/sum on integers, then the normalize walk.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ov, output int lat);
        int  ea, eb, d, alignCyc, normCyc, e, t;
        bit  sa, sb, sgn;
        longint fa, fb, s, m;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        sa = a[31];          sb = b[31];
        fa = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
        fb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
        ov = 0;
        if (ea == 255 || eb == 255) begin
            r = 32'h7FC00000; lat = 2; return;
        end
        if (eb > ea) begin
            t = ea; ea = eb; eb = t;
            s = fa; fa = fb; fb = s;
            sgn = sa; sa = sb; sb = sgn;
        end
        d = ea - eb;
        alignCyc = (d == 0) ? 1 : ((d >= 25) ? 2 : d + 1);
        fb = (d >= 25) ? 0 : (fb >> d);
        s = (sa ? -fa : fa) + (sb ? -fb : fb);
        if (s == 0) begin
            r = 32'h0; lat = 1 + alignCyc + 1 + 1; return;
        end
        sgn = (s < 0);
        m = sgn ? -s : s;
        e = ea;
        if (m >= (longint'(1) << 24)) begin m = m >> 1; e++; end
        normCyc = 0;
        forever begin
            normCyc++;
            if (e == 255) begin r = {sgn, 8'hFF, 23'd0}; ov = 1; break; end
            if (m >= (longint'(1) << 23)) begin r = {sgn, 8'(e), 23'(m)}; break; end
            if (e == 1) begin r = 32'h0; break; end
            m = m << 1; e--;
        end
        lat = 1 + alignCyc + 1 + normCyc + 1;
    endfunction

    logic        rstAtEdge = 1'b0;
    logic [31:0] lastRes   = 32'h0;
    always @(posedge Clock) rstAtEdge <= Reset_n;

    always @(negedge Clock) begin
        exp_t x;
        if (!rstAtEdge) begin
            lastRes = 32'h0;
        end else if (Done) begin
            if (expQ.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done actual=1 required=0 result=%h", Result);
            end else begin
                x = expQ.pop_front();
                chk("result", Result, x.r);
                chk("overflow", 32'(Overflow), 32'(x.ov));
                chk("latency", 32'(int'(($time - x.t0) / 10)), 32'(x.lat - 1));
                chk("ready_in_done", 32'(Ready), 32'd0);
            end
            lastRes = Result;
        end else begin
            chk("hold", Result, lastRes);
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        int g;
        g = 0;
        @(negedge Clock);
        while (!Ready && g < 200) begin @(negedge Clock); g++; end
        if (g >= 200) begin
            checks++; failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        A = a; B = b; Start = 1'b1;
        model(a, b, x.r, x.ov, x.lat);
        x.t0 = $time;
        expQ.push_back(x);
    endtask

    task automatic doOp(input logic [31:0] a, input logic [31:0] b);
        launch(a, b);
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic pinModel(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input bit ov, input int lat);
        logic [31:0] mr; bit mo; int ml;
        model(a, b, mr, mo, ml);
        chk({name, "_r"}, mr, r);
        chk({name, "_ov"}, 32'(mo), 32'(ov));
        chk({name, "_lat"}, 32'(ml), 32'(lat));
    endtask

    typedef struct { logic [31:0] a; logic [31:0] b; } vec_t;
    vec_t vecs[] = '{
        '{32'h3F800000, 32'h3F800000}, '{32'h3FC00000, 32'h3E800000},
        '{32'h40400000, 32'hBF800000}, '{32'h3F800000, 32'hBF800000},
        '{32'h3F800000, 32'h30800000}, '{32'h7F7FFFFF, 32'h7F7FFFFF},
        '{32'h7F800000, 32'h3F800000}, '{32'h3F800000, 32'h7F800000},
        '{32'h3F800000, 32'hBF400000}, '{32'h00000000, 32'h00000000},
        '{32'h00400000, 32'h3F800000}, '{32'h00C00000, 32'h80800000},
        '{32'hC0000000, 32'hC0000000}, '{32'h40490FDB, 32'hC02DF854},
        '{32'h3E800000, 32'h3FC00000}, '{32'h4B7FFFFF, 32'h3F800000}
    };

    initial begin
        int g, dones;
        Reset_n = 1'b0; Start = 1'b0; A = 32'h0; B = 32'h0;
        repeat (3) @(negedge Clock);
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_result", Result, 32'h0);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        Reset_n = 1'b1;

        pinModel("pin_1p1", 32'h3F800000, 32'h3F800000, 32'h40000000, 0, 5);
        pinModel("pin_align3", 32'h3FC00000, 32'h3E800000, 32'h3FE00000, 0, 7);
        pinModel("pin_sub", 32'h40400000, 32'hBF800000, 32'h40000000, 0, 6);
        pinModel("pin_zero", 32'h3F800000, 32'hBF800000, 32'h00000000, 0, 4);
        pinModel("pin_far", 32'h3F800000, 32'h30800000, 32'h3F800000, 0, 6);
        pinModel("pin_ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 5);
        pinModel("pin_nan", 32'h7F800000, 32'h3F800000, 32'h7FC00000, 0, 2);
        pinModel("pin_lshift", 32'h3F800000, 32'hBF400000, 32'h3E800000, 0, 8);

        foreach (vecs[i]) doOp(vecs[i].a, vecs[i].b);

        // Start pulses while busy must be ignored.
        launch(32'h3FC00000, 32'h3E800000);
        @(negedge Clock);
        A = 32'h40400000; B = 32'h40400000;
        @(negedge Clock);
        Start = 1'b0;

        g = 0;
        while (expQ.size() != 0 && g < 200) begin @(negedge Clock); g++; end
        chk("drain", 32'(expQ.size()), 32'd0);

        // Reset during ALIGN discards the operation.
        launch(32'h3F800000, 32'h30800000);
        @(negedge Clock);
        Start = 1'b0;
        Reset_n = 1'b0;
        expQ.delete();
        @(negedge Clock);
        chk("midrst_ready", 32'(Ready), 32'd1);
        chk("midrst_done", 32'(Done), 32'd0);
        chk("midrst_result", Result, 32'h0);
        Reset_n = 1'b1;
        dones = 0;
        repeat (12) begin @(negedge Clock); if (Done) dones++; end
        chk("midrst_no_done", 32'(dones), 32'd0);

        doOp(32'h3F800000, 32'h3F800000);
        g = 0;
        while (expQ.size() != 0 && g < 200) begin @(negedge Clock); g++; end
        chk("final_drain", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
